// File: rtl/fb_arbiter_if.sv
// Port bundle between the framebuffer arbiter, the display pipeline,
// the host pixel writer and the block RAM.
//
// Host write handshake: a transfer happens at every rising clk edge where
// wr_valid && wr_ready are both high. The writer holds wr_x/wr_y/wr_data
// stable while wr_valid is high and wr_ready is low; wr_ready never depends
// on wr_valid, so the writer may wait for it before raising wr_valid.
interface fb_arbiter_if;
  logic        disp_req;
  logic [9:0]  disp_col;
  logic [9:0]  disp_row;
  logic [7:0]  disp_color;
  logic        wr_valid;
  logic        wr_ready;
  logic [9:0]  wr_x;
  logic [9:0]  wr_y;
  logic [7:0]  wr_data;
  logic        wr_drop;
  logic        mem_en;
  logic        mem_we;
  logic [18:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        clr_flags;
  logic        disp_ovr;
  logic [1:0]  dbg_state;

  modport slave (
    input  disp_req, disp_col, disp_row, wr_valid, wr_x, wr_y, wr_data,
           mem_rdata, clr_flags,
    output disp_color, wr_ready, wr_drop, mem_en, mem_we, mem_addr,
           mem_wdata, disp_ovr, dbg_state
  );

  modport master (
    output disp_req, disp_col, disp_row, wr_valid, wr_x, wr_y, wr_data,
           mem_rdata, clr_flags,
    input  disp_color, wr_ready, wr_drop, mem_en, mem_we, mem_addr,
           mem_wdata, disp_ovr, dbg_state
  );
endinterface

// File: rtl/fb_arbiter.sv
// Framebuffer port arbiter: display fetches own the RAM port in their read
// cycle; buffered host writes take every other cycle. dbg_state shows the
// fetch FSM state.
module fb_arbiter #(
  parameter int H_OFS = 48,
  parameter int V_OFS = 33,
  parameter int H_ACT = 640,
  parameter int V_ACT = 480
) (
  input  logic        clk,
  input  logic        rst,
  fb_arbiter_if.slave bus
);
  localparam logic [9:0] H_OFS_W = 10'(H_OFS);
  localparam logic [9:0] V_OFS_W = 10'(V_OFS);
  localparam logic [9:0] H_ACT_W = 10'(H_ACT);
  localparam logic [9:0] V_ACT_W = 10'(V_ACT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RD   = 2'd2,
    CAP  = 2'd3
  } state_t;

  state_t      state;
  logic [9:0]  fetch_x;
  logic [9:0]  fetch_y;
  logic        in_frame;
  logic [9:0]  req_x;
  logic [9:0]  req_y;
  logic [18:0] fetch_addr;
  logic [18:0] push_addr;

  logic [26:0] fifo_mem [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  count;
  logic        wr_fire;
  logic        wr_in_range;
  logic        push;
  logic        pop;

  // y*640 + x without a multiplier.
  function automatic logic [18:0] pix_addr(input logic [9:0] x, input logic [9:0] y);
    return ({9'd0, y} << 9) + ({9'd0, y} << 7) + {9'd0, x};
  endfunction

  assign req_x       = bus.disp_col - H_OFS_W;
  assign req_y       = bus.disp_row - V_OFS_W;
  assign fetch_addr  = pix_addr(fetch_x, fetch_y);
  assign push_addr   = pix_addr(bus.wr_x, bus.wr_y);

  assign wr_in_range = (bus.wr_x < H_ACT_W) && (bus.wr_y < V_ACT_W);
  assign bus.wr_ready = (count != 3'd4);
  assign wr_fire     = bus.wr_valid && bus.wr_ready;
  assign push        = wr_fire && wr_in_range;
  // Only ADDR leads into RD, so every other edge may carry a write.
  assign pop         = (state != ADDR) && (count != 3'd0);
  assign bus.dbg_state = state;

  // FIFO pointers and occupancy; a full FIFO refuses pushes even when popping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: ;
      endcase
    end
  end

  // FIFO storage: address is resolved at push time.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {push_addr, bus.wr_data};
  end

  // Fetch FSM plus registered RAM port, color, drop pulse and overrun flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      fetch_x        <= 10'd0;
      fetch_y        <= 10'd0;
      in_frame       <= 1'b0;
      bus.disp_color <= 8'd0;
      bus.mem_en     <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= 19'd0;
      bus.mem_wdata  <= 8'd0;
      bus.wr_drop    <= 1'b0;
      bus.disp_ovr   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.disp_req) begin
            state    <= ADDR;
            fetch_x  <= req_x;
            fetch_y  <= req_y;
            in_frame <= (req_x < H_ACT_W) && (req_y < V_ACT_W);
          end
        end
        ADDR: state <= RD;
        RD:   state <= CAP;
        CAP: begin
          state          <= IDLE;
          bus.disp_color <= in_frame ? bus.mem_rdata : 8'd0;
        end
        default: state <= IDLE;
      endcase

      // The RD cycle belongs to the display even when the pixel is off-frame.
      if (state == ADDR) begin
        bus.mem_en   <= in_frame;
        bus.mem_we   <= 1'b0;
        bus.mem_addr <= fetch_addr;
      end else if (pop) begin
        bus.mem_en    <= 1'b1;
        bus.mem_we    <= 1'b1;
        bus.mem_addr  <= fifo_mem[rd_ptr][26:8];
        bus.mem_wdata <= fifo_mem[rd_ptr][7:0];
      end else begin
        bus.mem_en <= 1'b0;
        bus.mem_we <= 1'b0;
      end

      bus.wr_drop <= wr_fire && !wr_in_range;

      // A new overrun wins over a simultaneous clear.
      if (bus.disp_req && (state != IDLE)) bus.disp_ovr <= 1'b1;
      else if (bus.clr_flags)              bus.disp_ovr <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fb_arbiter.sv
// Bench for fb_arbiter: RAM model, write/color scoreboards, table of
// display fetches, then hand-written multi-cycle sequences.
module tb_fb_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  fb_arbiter_if bus();

  fb_arbiter #(.H_OFS(48), .V_OFS(33), .H_ACT(640), .V_ACT(480)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
    $fatal(1);
  end

  // ---------------- RAM model (1-cycle read latency) ----------------
  logic [7:0] ram [0:307199];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        if (bus.mem_addr < 19'd307200) ram[bus.mem_addr] <= bus.mem_wdata;
      end else begin
        bus.mem_rdata <= (bus.mem_addr < 19'd307200) ? ram[bus.mem_addr] : 8'h00;
      end
    end
  end

  // ---------------- checking core ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [26:0] exp_q[$];
  logic [7:0]  color_q[$];

  int          age = 0;
  logic        exp_in = 1'b0;
  logic [18:0] exp_raddr = 19'd0;
  logic        ovr_m = 1'b0;
  logic        drop_pend = 1'b0;
  logic [7:0]  exp_color = 8'd0;
  int          pushes = 0;
  int          writes_seen = 0;
  int          drops_seen = 0;
  logic        last_rd_en = 1'b0;
  logic [18:0] last_rd_addr = 19'd0;
  logic        m_busy;
  logic [9:0]  mx, my;
  logic [18:0] m_addr;
  logic [26:0] m_head;

  // Track handshakes and fetch progress from the inputs at each edge.
  always @(posedge clk) begin
    if (rst) begin
      age = 0; ovr_m = 1'b0; drop_pend = 1'b0; exp_color = 8'd0;
      exp_q.delete(); color_q.delete();
      pushes = 0; writes_seen = 0;
    end else begin
      if (bus.wr_valid && bus.wr_ready) begin
        if (bus.wr_x < 10'd640 && bus.wr_y < 10'd480) begin
          m_addr = {9'd0, bus.wr_y} * 19'd640 + {9'd0, bus.wr_x};
          exp_q.push_back({m_addr, bus.wr_data});
          pushes++;
          drop_pend = 1'b0;
        end else begin
          drop_pend = 1'b1;
        end
      end else begin
        drop_pend = 1'b0;
      end

      m_busy = (age >= 1) && (age <= 3);
      if (bus.disp_req && m_busy)  ovr_m = 1'b1;
      else if (bus.clr_flags)      ovr_m = 1'b0;

      if (bus.disp_req && !m_busy) begin
        mx = bus.disp_col - 10'd48;
        my = bus.disp_row - 10'd33;
        exp_in = (mx < 10'd640) && (my < 10'd480);
        exp_raddr = {9'd0, my} * 19'd640 + {9'd0, mx};
        color_q.push_back(exp_in ? ram[exp_raddr] : 8'h00);
        age = 1;
      end else if (age == 4) begin
        age = 0;
      end else if (age != 0) begin
        age++;
        if (age == 4) begin
          if (color_q.size() != 0) exp_color = color_q.pop_front();
        end
      end
    end
  end

  // Compare registered outputs mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      chk("disp_color", bus.disp_color, exp_color);
      chk("disp_ovr", bus.disp_ovr, ovr_m);
      chk("wr_drop", bus.wr_drop, drop_pend);
      if (bus.wr_drop) drops_seen++;
      if (bus.mem_en && bus.mem_we) begin
        writes_seen++;
        chk("write_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          m_head = exp_q.pop_front();
          chk("write_addr_data", {bus.mem_addr, bus.mem_wdata}, m_head);
        end
      end
      chk("wr_ready", bus.wr_ready, (pushes - writes_seen) < 4);
      if (age == 2) begin
        chk("rd_cycle_en", bus.mem_en, exp_in);
        chk("rd_cycle_we", bus.mem_we, 0);
        if (exp_in) chk("rd_cycle_addr", bus.mem_addr, exp_raddr);
        last_rd_en   = bus.mem_en;
        last_rd_addr = bus.mem_addr;
      end else begin
        chk("read_outside_rd", bus.mem_en && !bus.mem_we, 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic fetch(input logic [9:0] col, input logic [9:0] row);
    bus.disp_col = col;
    bus.disp_row = row;
    bus.disp_req = 1'b1;
    tick();
    bus.disp_req = 1'b0;
  endtask

  task automatic fetch_rand();
    logic [9:0] c, r, fx, fy;
    logic [18:0] a;
    c = 10'($urandom_range(0, 799));
    r = 10'($urandom_range(0, 432));
    fx = c - 10'd48;
    fy = r - 10'd33;
    if (fx < 10'd640 && fy < 10'd480) begin
      a = {9'd0, fy} * 19'd640 + {9'd0, fx};
      ram[a] <= 8'($urandom);
    end
    fetch(c, r);
  endtask

  task automatic push_write(input logic [9:0] x, input logic [9:0] y, input logic [7:0] d);
    logic hs;
    logic done;
    done = 1'b0;
    bus.wr_x = x;
    bus.wr_y = y;
    bus.wr_data = d;
    bus.wr_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      hs = bus.wr_ready;
      tick();
      if (hs) done = 1'b1;
    end
    bus.wr_valid = 1'b0;
    chk("push_handshake", done, 1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic check_reset_vals();
    chk("rst_disp_color", bus.disp_color, 0);
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_wr_ready", bus.wr_ready, 1);
    chk("rst_wr_drop", bus.wr_drop, 0);
    chk("rst_disp_ovr", bus.disp_ovr, 0);
    chk("rst_state", bus.dbg_state, 0);
  endtask

  // ---------------- stimulus table ----------------
  typedef struct {
    logic [9:0]  col;
    logic [9:0]  row;
    logic [7:0]  val;
    logic        exp_en;
    logic [18:0] exp_addr;
    logic [7:0]  exp_color;
  } vec_t;

  vec_t vecs[7];
  logic stop_wr = 1'b0;
  int   win_start, win_end, w0, d0, mem_seen;

  initial begin
    bus.disp_req = 1'b0; bus.disp_col = '0; bus.disp_row = '0;
    bus.wr_valid = 1'b0; bus.wr_x = '0; bus.wr_y = '0; bus.wr_data = '0;
    bus.clr_flags = 1'b0;

    vecs[0] = '{10'd48,  10'd33,  8'hA5, 1'b1, 19'd0,      8'hA5};
    vecs[1] = '{10'd687, 10'd512, 8'h3C, 1'b1, 19'd307199, 8'h3C};
    vecs[2] = '{10'd700, 10'd33,  8'h55, 1'b0, 19'd0,      8'h00};
    vecs[3] = '{10'd47,  10'd33,  8'h66, 1'b0, 19'd0,      8'h00};
    vecs[4] = '{10'd148, 10'd43,  8'h5A, 1'b1, 19'd6500,   8'h5A};
    vecs[5] = '{10'd48,  10'd512, 8'hC3, 1'b1, 19'd306560, 8'hC3};
    vecs[6] = '{10'd0,   10'd0,   8'h11, 1'b0, 19'd0,      8'h00};

    // Reset values, during and after reset.
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals();
    rst = 1'b0;
    tick();
    check_reset_vals();

    // Table of single display fetches.
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].exp_en) ram[vecs[i].exp_addr] <= vecs[i].val;
      tick();
      fetch(vecs[i].col, vecs[i].row);
      repeat (3) tick();
      chk("tbl_rd_en", last_rd_en, vecs[i].exp_en);
      if (vecs[i].exp_en) chk("tbl_rd_addr", last_rd_addr, vecs[i].exp_addr);
      chk("tbl_color", bus.disp_color, vecs[i].exp_color);
      tick();
    end

    // Six back-to-back writes while the display is idle.
    w0 = writes_seen;
    push_write(10'd5,   10'd2,   8'h81);
    push_write(10'd639, 10'd479, 8'h82);
    push_write(10'd0,   10'd1,   8'h83);
    push_write(10'd5,   10'd2,   8'h84);
    push_write(10'd10,  10'd300, 8'h85);
    push_write(10'd11,  10'd300, 8'h86);
    wait_drain();
    tick();
    chk("six_writes", writes_seen - w0, 6);
    chk("addr_1285_last", ram[1285], 8'h84);

    // Overrun: second request two cycles after the first.
    fetch(10'd48, 10'd33);
    tick();
    bus.disp_col = 10'd148; bus.disp_row = 10'd43; bus.disp_req = 1'b1;
    tick();
    bus.disp_req = 1'b0;
    repeat (4) tick();
    chk("ovr_held", bus.disp_ovr, 1);
    chk("ovr_first_color", bus.disp_color, 8'hA5);
    bus.clr_flags = 1'b1; tick(); bus.clr_flags = 1'b0;
    chk("ovr_cleared", bus.disp_ovr, 0);

    // Overrun and clear on the same edge: set wins.
    fetch(10'd48, 10'd33);
    bus.disp_req = 1'b1; bus.clr_flags = 1'b1;
    tick();
    bus.disp_req = 1'b0; bus.clr_flags = 1'b0;
    chk("ovr_set_wins", bus.disp_ovr, 1);
    repeat (3) tick();
    bus.clr_flags = 1'b1; tick(); bus.clr_flags = 1'b0;
    chk("ovr_cleared2", bus.disp_ovr, 0);

    // Out-of-range write: handshake completes, pulse, no RAM write.
    w0 = writes_seen; d0 = drops_seen;
    push_write(10'd640, 10'd10, 8'h77);
    repeat (4) tick();
    chk("oor_drop_pulse", drops_seen - d0, 1);
    chk("oor_no_write", writes_seen - w0, 0);

    // Fetches every 4 cycles with a saturated write FIFO.
    stop_wr = 1'b0;
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          if (k == 10) win_start = writes_seen;
          fetch_rand();
          repeat (3) tick();
        end
        win_end = writes_seen;
        stop_wr = 1'b1;
      end
      begin
        while (!stop_wr)
          push_write(10'($urandom_range(0, 639)), 10'($urandom_range(400, 479)), 8'($urandom));
      end
    join
    chk("bw_3_of_4", win_end - win_start, 90);
    wait_drain();
    repeat (4) tick();

    // Reset in ADDR with a loaded FIFO.
    stop_wr = 1'b0;
    fork
      begin
        for (int k = 0; k < 12; k++) begin
          fetch_rand();
          repeat (3) tick();
        end
        chk("fifo_loaded", (pushes - writes_seen) >= 3, 1);
        fetch_rand();
        chk("in_addr_state", bus.dbg_state, 1);
        rst = 1'b1;
        stop_wr = 1'b1;
        #1;
        check_reset_vals();
      end
      begin
        while (!stop_wr)
          push_write(10'($urandom_range(0, 639)), 10'($urandom_range(400, 479)), 8'($urandom));
      end
    join
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check_reset_vals();
    mem_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.mem_en) mem_seen++;
    end
    chk("no_mem_after_rst", mem_seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
